tone_osc: RTL and testbench

- Consumer end of the note/octave frequency-divider lookup: takes the 19-bit divider word and produces an audio-rate square wave.
- Divider value = clock cycles per half-period, so f_out = f_clk / (2*divider).
- Divider changes are double-buffered and applied only at a full-period boundary, which gives glitch-free note changes.
- Sits between the divider LUT and the mixer/PWM output stage.

---
 rtl/synth_pkg.sv | 20 ++
 rtl/half_period_cnt.sv | 34 +++
 rtl/tone_osc.sv | 123 ++++++++++++
 tb/tb_tone_osc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: widths, state encoding and amplitude constants shared by the
// tone oscillator and the divider lookup that feeds it.
// No ports; imported by tone_osc and half_period_cnt.
package synth_pkg;

  localparam int DIV_W = 19;
  localparam int AMP_W = 8;

  typedef logic [DIV_W-1:0] div_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } osc_state_t;

  localparam logic [AMP_W-1:0] AMP_HIGH = '1;
  localparam logic [AMP_W-1:0] AMP_LOW  = '0;

endpackage

// File: rtl/half_period_cnt.sv
// half_period_cnt: up-counter measuring the current half-period.
// Ports:
//   clk, n_rst : clock, async active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count enable
//   lim        : half-period length in cycles (act_div)
//   cnt        : current count, 0 .. lim-1
//   tc         : terminal count, high when cnt == lim-1
module half_period_cnt
  import synth_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr,
  input  logic       inc,
  input  div_t       lim,
  output div_t       cnt,
  output logic       tc
);

  // lim is never 0 while counting, so lim-1 cannot wrap in use.
  assign tc = (cnt == (lim - DIV_W'(1)));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/tone_osc.sv
// tone_osc: square-wave tone generator driven by a half-period divider word.
// f_out = f_clk / (2 * act_div). New dividers are double-buffered and only
// take effect at a full-period boundary so note changes never glitch.
// Ports:
//   clk, n_rst  : clock, async active-low reset
//   en          : enable; low forces IDLE (muted)
//   div_in      : new divider (half-period length in clk cycles)
//   div_load    : one-cycle strobe capturing div_in
//   wave_out    : square wave (1 in HIGH)
//   sample_out  : AMP_HIGH when wave_out=1, else AMP_LOW
//   period_tick : one-cycle pulse in the first cycle of every HIGH
//   div_pending : a loaded divider waits for the period boundary
//
// state | meaning
// IDLE  | muted, counter held at 0, dividers load straight into act_div
// HIGH  | first half-period, wave_out=1
// LOW   | second half-period; terminal count is the period boundary
module tone_osc
  import synth_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  div_t             div_in,
  input  logic             div_load,
  output logic             wave_out,
  output logic [AMP_W-1:0] sample_out,
  output logic             period_tick,
  output logic             div_pending
);

  osc_state_t state, state_nxt;
  div_t       act_div, pend_div, div_nxt, cnt;
  logic       pending, tick_q, tc, cnt_clr, cnt_inc, period_end, take_div;

  half_period_cnt u_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .lim   (act_div),
    .cnt   (cnt),
    .tc    (tc)
  );

  assign cnt_clr    = (state == IDLE) || !en || tc;
  assign cnt_inc    = (state != IDLE);
  assign period_end = (state == LOW) && tc;

  // Value act_div takes whenever it is updated: a same-cycle load beats an
  // older pending value, which beats keeping the current one.
  always_comb begin
    div_nxt = act_div;
    if (div_load) begin
      div_nxt = div_in;
    end else if (pending) begin
      div_nxt = pend_div;
    end
  end

  assign take_div = (state == IDLE) || period_end || !en;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      act_div  <= '0;
      pend_div <= '0;
      pending  <= 1'b0;
    end else if (take_div) begin
      act_div <= div_nxt;
      pending <= 1'b0;
    end else if (div_load) begin
      pend_div <= div_in;
      pending  <= 1'b1;
    end
  end

  // State register; the tick is registered so every output decodes from flops.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      tick_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      tick_q <= (state_nxt == HIGH) && (state != HIGH);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // Start uses the registered act_div; a zero load in the same cycle
        // blocks the start so HIGH is never entered with a zero divider.
        if (en && (act_div != '0) && !(div_load && (div_in == '0))) begin
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (tc) begin
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (tc) begin
          state_nxt = (div_nxt != '0) ? HIGH : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wave_out    = (state == HIGH);
    sample_out  = (state == HIGH) ? AMP_HIGH : AMP_LOW;
    period_tick = tick_q;
    div_pending = pending;
  end

endmodule

// File: tb/tb_tone_osc.sv
module tb_tone_osc;
  import synth_pkg::*;

  logic             clk;
  logic             n_rst;
  logic             en;
  div_t             div_in;
  logic             div_load;
  logic             wave_out;
  logic [AMP_W-1:0] sample_out;
  logic             period_tick;
  logic             div_pending;

  typedef struct packed {
    logic w;
    logic t;
    logic p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  tone_osc dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .en          (en),
    .div_in      (div_in),
    .div_load    (div_load),
    .wave_out    (wave_out),
    .sample_out  (sample_out),
    .period_tick (period_tick),
    .div_pending (div_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: one expected entry per clock cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wave_out", 32'(wave_out), 32'(e.w));
      chk("sample_out", 32'(sample_out), e.w ? 32'hFF : 32'h00);
      chk("period_tick", 32'(period_tick), 32'(e.t));
      chk("div_pending", 32'(div_pending), 32'(e.p));
    end
  end

  // Push the expected outputs for the current cycle, then advance one clock.
  task automatic cyc(input logic w, input logic t, input logic p);
    exp_q.push_back(exp_t'{w, t, p});
    @(posedge clk);
    #1;
    div_load = 1'b0;
  endtask

  task automatic load(input logic [DIV_W-1:0] d);
    div_in   = d;
    div_load = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst    = 1'b0;
    en       = 1'b0;
    div_in   = '0;
    div_load = 1'b0;
    #2;
    chk("rst_wave", 32'(wave_out), 32'd0);
    chk("rst_sample", 32'(sample_out), 32'd0);
    chk("rst_tick", 32'(period_tick), 32'd0);
    chk("rst_pend", 32'(div_pending), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (2) cyc(0, 0, 0);

    // Divider 3: 1,1,1,0,0,0 with a tick every 6 cycles
    en = 1'b1;
    load(19'd3);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    repeat (2) begin
      cyc(1, 1, 0);
      repeat (2) cyc(1, 0, 0);
      repeat (3) cyc(0, 0, 0);
    end

    // Load 5 in the second HIGH cycle: period finishes 3/3, next is 5/5
    cyc(1, 1, 0);
    load(19'd5);
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    repeat (3) cyc(0, 0, 1);
    cyc(1, 1, 0);
    repeat (4) cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);

    // Load 7 then 4 within one period: 4 wins
    load(19'd7);
    cyc(1, 1, 0);
    repeat (4) cyc(1, 0, 1);
    cyc(0, 0, 1);
    load(19'd4);
    cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 1);
    cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);

    // Load 6 on the LOW terminal cycle: applied directly, never pending
    load(19'd6);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    repeat (5) cyc(1, 0, 0);
    repeat (6) cyc(0, 0, 0);

    // Divider 1: toggles every cycle
    load(19'd1);
    cyc(1, 1, 0);
    repeat (5) cyc(1, 0, 1);
    repeat (6) cyc(0, 0, 1);
    repeat (2) begin
      cyc(1, 1, 0);
      cyc(0, 0, 0);
    end

    // Pending 0 applied at period end: falls to IDLE, no further ticks
    load(19'd0);
    cyc(1, 1, 0);
    cyc(0, 0, 1);
    repeat (4) cyc(0, 0, 0);

    // Start from IDLE at 4, drop en mid-HIGH with a pending 2
    load(19'd4);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    load(19'd2);
    cyc(1, 0, 0);
    en = 1'b0;
    cyc(1, 0, 1);
    repeat (2) cyc(0, 0, 0);
    en = 1'b1;
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    repeat (2) cyc(0, 0, 0);
    load(19'd5);
    cyc(1, 1, 0);

    // Async reset mid-HIGH with a pending value
    #2;
    n_rst = 1'b0;
    en    = 1'b0;
    #1;
    chk("mid_rst_wave", 32'(wave_out), 32'd0);
    chk("mid_rst_sample", 32'(sample_out), 32'd0);
    chk("mid_rst_tick", 32'(period_tick), 32'd0);
    chk("mid_rst_pend", 32'(div_pending), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (2) cyc(0, 0, 0);
    en = 1'b1;
    repeat (2) cyc(0, 0, 0);

    // Maximum divider: first 3000 cycles of the half-period stay high
    load(19'h7FFFF);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    repeat (2999) cyc(1, 0, 0);
    en = 1'b0;
    cyc(1, 0, 0);
    cyc(0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      chk("queue_drain", 32'(exp_q.size()), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
